// File: rtl/leaf_port_adapter.sv
// PE-side endpoint of a BFT leaf link: packs PE words into packets (replaying on resend)
// and unpacks arriving packets into a small first-word-fall-through receive FIFO.
module leaf_port_adapter #(
   parameter int payload_sz = 43,
   parameter int addr_sz    = 5,
   parameter int p_sz       = 49,
   parameter int rx_depth   = 4,
   parameter int cnt_sz     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [addr_sz-1:0]    s_dest,
   input  logic [payload_sz-1:0] s_payload,
   output logic [p_sz-1:0]       leaf_in,
   input  logic                  resend,
   input  logic [p_sz-1:0]       leaf_out,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [addr_sz-1:0]    m_addr,
   output logic [payload_sz-1:0] m_payload,
   output logic [cnt_sz-1:0]     retry_cnt,
   output logic [cnt_sz-1:0]     rx_drop_cnt
);

   localparam int HW = addr_sz + payload_sz;
   localparam int AW = $clog2(rx_depth);

   typedef enum logic [1:0] {IDLE, SEND, CHECK} txState_t;

   txState_t                r_state;
   txState_t                w_nextState;
   logic                    w_sReady;
   logic                    w_accept;
   logic                    w_retry;
   logic [HW-1:0]           r_hold;
   logic [HW-1:0]           w_nextHold;
   logic [p_sz-1:0]         r_leafIn;
   logic [cnt_sz-1:0]       r_retryCnt;

   logic [HW-1:0]           r_mem [rx_depth];
   logic [AW:0]             r_wrPtr;
   logic [AW:0]             r_rdPtr;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_pushReq;
   logic                    w_push;
   logic                    w_drop;
   logic [cnt_sz-1:0]       r_dropCnt;
   logic [HW-1:0]           w_head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (s_valid) w_nextState = SEND;
         SEND:    w_nextState = CHECK;
         CHECK:   w_nextState = (resend || s_valid) ? SEND : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // resend only has meaning in CHECK, where it refers to the preceding SEND cycle
   always_comb begin
      w_sReady = (r_state == IDLE) || ((r_state == CHECK) && !resend);
      w_accept = w_sReady && s_valid;
      w_retry  = (r_state == CHECK) && resend;
   end

   assign w_nextHold = w_accept ? {s_dest, s_payload} : r_hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold   <= '0;
         r_leafIn <= '0;
      end else begin
         r_hold   <= w_nextHold;
         r_leafIn <= (w_nextState == SEND) ? {1'b1, w_nextHold} : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          r_retryCnt <= '0;
      else if (w_retry && r_retryCnt != '1) r_retryCnt <= r_retryCnt + cnt_sz'(1);
   end

   // Gating with reset keeps s_ready low for the whole reset interval
   assign s_ready   = w_sReady && reset;
   assign leaf_in   = r_leafIn;
   assign retry_cnt = r_retryCnt;

   assign w_empty   = (r_wrPtr == r_rdPtr);
   assign w_full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_pop     = !w_empty && m_ready;
   assign w_pushReq = leaf_out[p_sz-1];
   // A pop frees the head slot this cycle, so a push into a full FIFO can reuse it
   assign w_push    = w_pushReq && (!w_full || w_pop);
   assign w_drop    = w_pushReq && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr[AW-1:0]] <= leaf_out[HW-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + (AW+1)'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        r_dropCnt <= '0;
      else if (w_drop && r_dropCnt != '1) r_dropCnt <= r_dropCnt + cnt_sz'(1);
   end

   assign w_head      = r_mem[r_rdPtr[AW-1:0]];
   assign m_valid     = !w_empty;
   assign m_addr      = w_head[HW-1:payload_sz];
   assign m_payload   = w_head[payload_sz-1:0];
   assign rx_drop_cnt = r_dropCnt;

endmodule

// File: tb/tb_leaf_port_adapter.sv
// Directed and randomized bench for leaf_port_adapter, checked against a
// transaction-level model (expected packet sequences, a receive queue and counters).
module tb_leaf_port_adapter;

   localparam int PAY   = 43;
   localparam int AD    = 5;
   localparam int PSZ   = 49;
   localparam int HW    = AD + PAY;
   localparam int DEPTH = 4;
   localparam int CNT   = 16;
   localparam int SATMAX = (1 << CNT) - 1;

   logic           clk = 1'b0;
   logic           reset;
   logic           s_valid;
   logic           s_ready;
   logic [AD-1:0]  s_dest;
   logic [PAY-1:0] s_payload;
   logic [PSZ-1:0] leaf_in;
   logic           resend;
   logic [PSZ-1:0] leaf_out;
   logic           m_valid;
   logic           m_ready;
   logic [AD-1:0]  m_addr;
   logic [PAY-1:0] m_payload;
   logic [CNT-1:0] retry_cnt;
   logic [CNT-1:0] rx_drop_cnt;

   int checks = 0;
   int errors = 0;
   int expRetry = 0;
   int expDrop = 0;
   logic [HW-1:0] rxq[$];

   leaf_port_adapter #(
      .payload_sz(PAY), .addr_sz(AD), .p_sz(PSZ), .rx_depth(DEPTH), .cnt_sz(CNT)
   ) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_dest(s_dest), .s_payload(s_payload),
      .leaf_in(leaf_in), .resend(resend), .leaf_out(leaf_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_payload(m_payload),
      .retry_cnt(retry_cnt), .rx_drop_cnt(rx_drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PSZ-1:0] mkPkt(input logic [AD-1:0] d, input logic [PAY-1:0] p);
      return {1'b1, d, p};
   endfunction

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_retry_cnt"}, 64'(retry_cnt), 64'(expRetry));
      checkOutput({tag, "_rx_drop_cnt"}, 64'(rx_drop_cnt), 64'(expDrop));
   endtask

   // One packet starting from IDLE, rejected k times before delivery
   task automatic applyStimulus(input logic [AD-1:0] d, input logic [PAY-1:0] p, input int k);
      s_valid = 1'b1; s_dest = d; s_payload = p; resend = 1'($urandom);
      #1;
      checkOutput("tx_idle_ready", 64'(s_ready), 64'(1));
      checkOutput("tx_idle_leaf", 64'(leaf_in), 64'(0));
      tick();
      s_valid = 1'b0; s_dest = AD'($urandom); s_payload = PAY'({$urandom, $urandom});
      for (int r = 0; r <= k; r++) begin
         resend = 1'($urandom);
         #1;
         checkOutput("tx_send_leaf", 64'(leaf_in), 64'(mkPkt(d, p)));
         checkOutput("tx_send_ready", 64'(s_ready), 64'(0));
         tick();
         resend = (r < k);
         #1;
         checkOutput("tx_check_leaf", 64'(leaf_in), 64'(0));
         checkOutput("tx_check_ready", 64'(s_ready), 64'(r >= k));
         tick();
         if (r < k && expRetry < SATMAX) expRetry++;
      end
      resend = 1'b0;
      checkCounters("tx");
   endtask

   // One RX cycle: compare head of the model queue, then apply push/pop rules
   task automatic rxStep(input logic push, input logic [HW-1:0] w, input logic mready);
      logic [HW-1:0] head;
      leaf_out = push ? {1'b1, w} : {1'b0, HW'({$urandom, $urandom})};
      m_ready = mready;
      #1;
      checkOutput("rx_m_valid", 64'(m_valid), 64'(rxq.size() != 0));
      if (rxq.size() != 0) begin
         head = rxq[0];
         checkOutput("rx_m_addr", 64'(m_addr), 64'(head[HW-1:PAY]));
         checkOutput("rx_m_payload", 64'(m_payload), 64'(head[PAY-1:0]));
         if (mready) void'(rxq.pop_front());
      end
      if (push) begin
         if (rxq.size() < DEPTH) rxq.push_back(w);
         else if (expDrop < SATMAX) expDrop++;
      end
      tick();
      leaf_out = '0;
      m_ready = 1'b0;
      checkOutput("rx_drop_cnt", 64'(rx_drop_cnt), 64'(expDrop));
   endtask

   initial begin
      logic [HW-1:0] words[4];
      logic [HW-1:0] w;

      reset = 1'b0; s_valid = 1'b0; s_dest = '0; s_payload = '0;
      resend = 1'b0; leaf_out = '0; m_ready = 1'b0;

      // Reset state
      tick(); tick();
      checkOutput("rst_leaf_in", 64'(leaf_in), 64'(0));
      checkOutput("rst_s_ready", 64'(s_ready), 64'(0));
      checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
      checkCounters("rst");
      reset = 1'b1;
      #1;
      checkOutput("rst_release_ready", 64'(s_ready), 64'(1));
      tick();

      // Single send, then a packet replayed twice
      applyStimulus(5'h03, 43'h1234, 0);
      applyStimulus(5'h1a, 43'h7ff_dead_beef, 2);
      checkOutput("replay_retry_cnt", 64'(retry_cnt), 64'(2));

      // Back-to-back: s_valid held with four distinct words
      for (int i = 0; i < 4; i++) words[i] = {AD'(i + 7), PAY'(43'h100 * (i + 1) + 5)};
      s_valid = 1'b1; {s_dest, s_payload} = words[0];
      #1;
      checkOutput("b2b_first_ready", 64'(s_ready), 64'(1));
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) {s_dest, s_payload} = words[i + 1];
         else s_valid = 1'b0;
         #1;
         checkOutput("b2b_send_leaf", 64'(leaf_in), 64'({1'b1, words[i]}));
         checkOutput("b2b_send_ready", 64'(s_ready), 64'(0));
         tick();
         #1;
         checkOutput("b2b_check_leaf", 64'(leaf_in), 64'(0));
         checkOutput("b2b_check_ready", 64'(s_ready), 64'(1));
         tick();
      end
      s_valid = 1'b0;

      // Randomized TX transactions with random replay counts
      for (int t = 0; t < 12; t++)
         applyStimulus(AD'($urandom), PAY'({$urandom, $urandom}), int'($urandom_range(0, 3)));

      // RX fill and overflow, then push+pop on a full FIFO, then drain
      for (int i = 0; i < 5; i++) rxStep(1'b1, {AD'(i + 1), PAY'(43'h5500 + i)}, 1'b0);
      checkOutput("rx_overflow_drop", 64'(rx_drop_cnt), 64'(1));
      rxStep(1'b1, {5'h1f, 43'h0abc_def0_1234}, 1'b1);
      for (int i = 0; i < 5; i++) rxStep(1'b0, '0, 1'b1);
      checkOutput("rx_drained", 64'(m_valid), 64'(0));

      // Randomized RX traffic
      for (int i = 0; i < 80; i++) begin
         w = HW'({$urandom, $urandom});
         rxStep(1'($urandom), w, ($urandom_range(0, 3) != 0));
      end

      // Async reset in the CHECK cycle of a replayed packet, FIFO non-empty
      rxStep(1'b1, {5'h02, 43'h42}, 1'b0);
      rxStep(1'b1, {5'h03, 43'h43}, 1'b0);
      s_valid = 1'b1; s_dest = 5'h11; s_payload = 43'h0777;
      tick();
      s_valid = 1'b0;
      tick();
      resend = 1'b1;
      tick();
      if (expRetry < SATMAX) expRetry++;
      resend = 1'b0;
      #1;
      checkOutput("rst_mid_replay_leaf", 64'(leaf_in), 64'(mkPkt(5'h11, 43'h0777)));
      tick();
      resend = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      expRetry = 0; expDrop = 0; rxq.delete();
      checkOutput("rst_mid_leaf_in", 64'(leaf_in), 64'(0));
      checkOutput("rst_mid_ready", 64'(s_ready), 64'(0));
      checkOutput("rst_mid_m_valid", 64'(m_valid), 64'(0));
      checkCounters("rst_mid");
      tick();
      resend = 1'b0;
      reset = 1'b1;
      #1;
      checkOutput("rst_after_ready", 64'(s_ready), 64'(1));
      tick();
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("rst_no_resend_leaf", 64'(leaf_in), 64'(0));
         tick();
      end
      applyStimulus(5'h09, 43'h00c0_ffee, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
